// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and default widths for the instruction/data
//                cache to main-memory arbiter.
//                  arb_state_t : transfer sequencer states
//                  owner_t     : which requester currently owns memory
//  Optional    : ARB_ROUND_ROBIN_EN (consumed by mem_arb_pick/mem_arbiter)
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 6;     // block address width
    localparam int DATA_W_DEF = 128;   // block width (4 x 32-bit words)

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pick
//  Description : Combinational grant picker. Given the instruction-cache and
//                data-cache request lines, returns the requester that should
//                own the next memory transfer.
//  Ports       : last_grant  in  owner of the previous transfer
//                                (only present with ARB_ROUND_ROBIN_EN)
//                icache_req  in  instruction cache wants a block read
//                dcache_req  in  data cache wants a block read or write
//                owner       out chosen requester, NONE when nobody asks
//  Optional    : ARB_ROUND_ROBIN_EN - on a tie, grant whoever was not granted
//                last; otherwise the data cache always wins a tie.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  owner_t last_grant,
`endif
    input  logic   icache_req,
    input  logic   dcache_req,
    output owner_t owner
);

    always_comb begin
        owner = NONE;
        if (icache_req && dcache_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            // Alternate on contention; last_grant resets to OWN_I so the
            // first tie goes to the data cache.
            owner = (last_grant == OWN_D) ? OWN_I : OWN_D;
`else
            owner = OWN_D;
`endif
        end else if (dcache_req) begin
            owner = OWN_D;
        end else if (icache_req) begin
            owner = OWN_I;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares a single block-wide main-memory port between the
//                instruction cache (read only) and the data cache
//                (read / write-back). One block per transfer, serialised by
//                an IDLE -> ISSUE -> WAIT -> DONE sequencer.
//  Ports       : CLK, RESET (async, active low)
//                I_READ/I_ADDRESS           instruction cache request
//                I_READDATA/I_BUSYWAIT      instruction cache response/stall
//                D_READ/D_WRITE/D_ADDRESS/D_WRITEDATA  data cache request
//                D_READDATA/D_BUSYWAIT      data cache response/stall
//                MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITEDATA  memory command
//                MEM_READDATA/MEM_BUSYWAIT  memory response
//  Optional    : ARB_ROUND_ROBIN_EN - alternate grants on contention using a
//                last-grant register; undefined gives fixed D-over-I.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_READ,
    input  logic [ADDR_W-1:0] I_ADDRESS,
    output logic [DATA_W-1:0] I_READDATA,
    output logic              I_BUSYWAIT,
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [ADDR_W-1:0] D_ADDRESS,
    input  logic [DATA_W-1:0] D_WRITEDATA,
    output logic [DATA_W-1:0] D_READDATA,
    output logic              D_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT
);

    arb_state_t state;
    arb_state_t state_next;
    owner_t     owner;
    owner_t     pick_owner;
    logic       d_req;
    logic       grant;
    logic       xfer_end;

    // A simultaneous D_READ and D_WRITE is a single write-back request.
    assign d_req = D_READ | D_WRITE;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_grant;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            last_grant <= OWN_I;
        end else if (state == DONE) begin
            last_grant <= owner;
        end
    end
`endif

    mem_arb_pick u_pick (
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant (last_grant),
`endif
        .icache_req (I_READ),
        .dcache_req (d_req),
        .owner      (pick_owner)
    );

    // ------------------------------------------------------------------
    // Sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: next state and datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        xfer_end   = 1'b0;
        case (state)
            IDLE: begin
                if (I_READ || d_req) begin
                    grant      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // Memory may still show a low busy left over from before it
                // noticed the strobe; only a high busy proves it accepted.
                if (MEM_BUSYWAIT) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (!MEM_BUSYWAIT) begin
                    xfer_end   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered memory command, owner and per-requester read data
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            owner         <= NONE;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
            I_READDATA    <= '0;
            D_READDATA    <= '0;
        end else begin
            if (grant) begin
                owner <= pick_owner;
                if (pick_owner == OWN_D) begin
                    MEM_ADDRESS   <= D_ADDRESS;
                    MEM_WRITEDATA <= D_WRITEDATA;
                    MEM_WRITE     <= D_WRITE;
                    MEM_READ      <= ~D_WRITE;
                end else begin
                    MEM_ADDRESS   <= I_ADDRESS;
                    MEM_WRITEDATA <= '0;
                    MEM_WRITE     <= 1'b0;
                    MEM_READ      <= 1'b1;
                end
            end

            if (xfer_end) begin
                if (MEM_READ) begin
                    if (owner == OWN_I) begin
                        I_READDATA <= MEM_READDATA;
                    end else if (owner == OWN_D) begin
                        D_READDATA <= MEM_READDATA;
                    end
                end
                MEM_READ  <= 1'b0;
                MEM_WRITE <= 1'b0;
            end

            if (state == DONE) begin
                owner <= NONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stalls: a requester is released only in the DONE cycle of its own
    // transfer, so the losing requester stays stalled the whole time.
    // ------------------------------------------------------------------
    assign I_BUSYWAIT = I_READ & ~((state == DONE) && (owner == OWN_I));
    assign D_BUSYWAIT = d_req  & ~((state == DONE) && (owner == OWN_D));

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one main-memory port between the instruction cache (read-only) and the data cache (read/write), one block per transfer.
- Serialises transfers through a 4-state FSM.
- Drives per-requester BUSYWAIT so the pc stalls through its existing dBUSYWAIT/iBUSYWAIT inputs.
- Sits between both caches and data_memory.

Parameters:
ADDR_W, 6, block address width.
DATA_W, 128, block width in bits (4 x 32-bit words).

Ports:
CLK  input  1  system clock; all state changes on posedge.
RESET  input  1  asynchronous, active-low reset; 0 = reset asserted.
I_READ  input  1  instruction cache block-read request.
I_ADDRESS  input  ADDR_W  instruction block address.
I_READDATA  output  DATA_W  block returned to the instruction cache.
I_BUSYWAIT  output  1  stall to the instruction cache.
D_READ  input  1  data cache block-read request.
D_WRITE  input  1  data cache block-write (write-back) request.
D_ADDRESS  input  ADDR_W  data block address.
D_WRITEDATA  input  DATA_W  block to write.
D_READDATA  output  DATA_W  block returned to the data cache.
D_BUSYWAIT  output  1  stall to the data cache.
MEM_READ  output  1  memory read strobe.
MEM_WRITE  output  1  memory write strobe.
MEM_ADDRESS  output  ADDR_W  memory block address.
MEM_WRITEDATA  output  DATA_W  memory write block.
MEM_READDATA  input  DATA_W  memory read block.
MEM_BUSYWAIT  input  1  memory busy; high while a transfer is in flight.

Behaviour:
- Reset, asynchronous while RESET=0: state=IDLE, owner=NONE, all MEM_* outputs 0, I/D_READDATA 0, last-grant=I. Any in-flight transfer is abandoned; memory sees its strobes drop.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs except BUSYWAIT are registered.
- IDLE: on a posedge with a request pending, choose the owner, latch its address/data/op into MEM_*, raise MEM_READ or MEM_WRITE, go to ISSUE.
- Arbitration in IDLE: D wins over I when both request.
- D_READ and D_WRITE both high: treated as a write.
- ISSUE: hold MEM_*. When MEM_BUSYWAIT=1, go to WAIT. This guard prevents a stale low MEM_BUSYWAIT from completing the transfer early.
- WAIT: hold MEM_*. When MEM_BUSYWAIT=0, go to DONE. On a read, capture MEM_READDATA into the owner's READDATA register in that same edge. Clear MEM_READ/MEM_WRITE in that same edge.
- DONE: exactly one cycle. Update last-grant, then go to IDLE.
- Requester-side BUSYWAIT is combinational: X_BUSYWAIT = X request & !(state==DONE & owner==X).
  - A requester sees BUSYWAIT=0 only in the DONE cycle of its own transfer.
  - The waiting requester stays stalled throughout.
- Requesters must drop their request at the posedge ending DONE. A request still high in IDLE is treated as new.
- READDATA registers hold their value until the next read completes for that requester. Writes never alter D_READDATA.
- Minimum occupancy per transfer: 1 IDLE edge + ISSUE (>=1) + WAIT (>=1) + DONE (1).
- The arbiter never grants while not in IDLE. Requests arriving mid-transfer wait, and their BUSYWAIT is already high.
- Address widths pass through unchanged; no arithmetic.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous I and D requests in IDLE, grant the requester that was not granted last. Last-grant resets to I, so D wins the first tie.
- Undefined: fixed D-over-I priority. The last-grant register is not implemented.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, DONE}
  - owner encoding {NONE, OWN_I, OWN_D}
  - ADDR_W/DATA_W defaults.
- One natural sub-module: mem_arb_pick, a combinational grant picker.
  - Inputs: I_READ, D_READ|D_WRITE, last-grant.
  - Output: owner.
  - Compile-time priority/round-robin select.

Test Plan:
- Reset mid-transfer: assert RESET=0 during WAIT of a D read -> all MEM_* 0, state IDLE, READDATA 0, BUSYWAITs follow the requests only.
- Single I read: I_ADDRESS=6'h05, memory raises busy 1 cycle later, holds 5 cycles, returns 128'hA5..A5 -> I_READDATA=128'hA5..A5, I_BUSYWAIT low for exactly one cycle, MEM_READ high from the IDLE edge until WAIT exits.
- D write: D_WRITE=1, D_ADDRESS=6'h3F, D_WRITEDATA=128'h1234 -> MEM_WRITE=1, MEM_ADDRESS=6'h3F, MEM_WRITEDATA=128'h1234 held until busy falls; D_READDATA unchanged.
- Simultaneous I read 6'h01 and D read 6'h02 (fixed priority) -> D served first, I_BUSYWAIT held high throughout, then I served; MEM_ADDRESS sequence 02 then 01.
- ARB_ROUND_ROBIN_EN, both requesting continuously for 4 transfers -> grant order D, I, D, I.
- Stale-busy guard: memory keeps MEM_BUSYWAIT=0 for 2 cycles after the strobe before raising it -> FSM stays in ISSUE, no early DONE, data captured only after the later falling edge.
